// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3/APB4 requester: a valid/ready request channel in,
// SETUP/ACCESS phases out, and read data / error status on a valid/ready response channel.
module apb_master_bridge #(
    parameter int REGWIDTH     = 32,
    parameter int G_ADDR_WIDTH = 7,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [G_ADDR_WIDTH-1:0] req_addr,
    input  logic [REGWIDTH-1:0]     req_wdata,
    input  logic [REGWIDTH/8-1:0]   req_strb,
    input  logic [2:0]              req_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [REGWIDTH-1:0]     rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic                    m_apb_psel,
    output logic                    m_apb_penable,
    output logic                    m_apb_pwrite,
    output logic [2:0]              m_apb_pprot,
    output logic [G_ADDR_WIDTH-1:0] m_apb_paddr,
    output logic [REGWIDTH-1:0]     m_apb_pwdata,
    output logic [REGWIDTH/8-1:0]   m_apb_pstrb,
    input  logic                    m_apb_pready,
    input  logic [REGWIDTH-1:0]     m_apb_prdata,
    input  logic                    m_apb_pslverr
);

    // state  | meaning
    // IDLE   | req_ready high, waiting for a request
    // SETUP  | psel high, penable low, APB fields driven from captured request
    // ACCESS | psel and penable high, waiting for pready or the timeout
    // RESP   | rsp_valid high, response held until rsp_ready

    localparam int SW = REGWIDTH / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;

    assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == TO_VAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (req_valid) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (m_apb_pready || timeout_hit) state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Handshake/phase flags are registered from the next state so that every
    // output is a flop and all of them read 0 while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready     <= 1'b0;
            m_apb_psel    <= 1'b0;
            m_apb_penable <= 1'b0;
            rsp_valid     <= 1'b0;
        end else begin
            req_ready     <= (state_nxt == ST_IDLE);
            m_apb_psel    <= (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
            m_apb_penable <= (state_nxt == ST_ACCESS);
            rsp_valid     <= (state_nxt == ST_RESP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_apb_pwrite <= 1'b0;
            m_apb_pprot  <= '0;
            m_apb_paddr  <= '0;
            m_apb_pwdata <= '0;
            m_apb_pstrb  <= '0;
        end else if (state == ST_IDLE && req_valid) begin
            m_apb_pwrite <= req_write;
            m_apb_pprot  <= req_prot;
            m_apb_paddr  <= req_addr;
            m_apb_pwdata <= req_wdata;
            m_apb_pstrb  <= req_write ? req_strb : {SW{1'b0}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state != ST_ACCESS) begin
            wait_cnt <= '0;
        end else if (!m_apb_pready && wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // pready is tested first so a completion on the timeout edge is a normal one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (state == ST_ACCESS) begin
            if (m_apb_pready) begin
                rsp_rdata   <= m_apb_pwrite ? '0 : m_apb_prdata;
                rsp_slverr  <= m_apb_pslverr;
                rsp_timeout <= 1'b0;
            end else if (timeout_hit) begin
                rsp_rdata   <= '0;
                rsp_slverr  <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: vector table of single transactions against
// a small APB slave model, plus hand-written backpressure and reset sequences.
module tb_apb_master_bridge;

    localparam int TB_TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        m_apb_psel;
    logic        m_apb_penable;
    logic        m_apb_pwrite;
    logic [2:0]  m_apb_pprot;
    logic [6:0]  m_apb_paddr;
    logic [31:0] m_apb_pwdata;
    logic [3:0]  m_apb_pstrb;
    logic        m_apb_pready;
    logic [31:0] m_apb_prdata;
    logic        m_apb_pslverr;

    apb_master_bridge #(
        .REGWIDTH    (32),
        .G_ADDR_WIDTH(7),
        .TIMEOUT     (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_strb     (req_strb),
        .req_prot     (req_prot),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_slverr   (rsp_slverr),
        .rsp_timeout  (rsp_timeout),
        .m_apb_psel   (m_apb_psel),
        .m_apb_penable(m_apb_penable),
        .m_apb_pwrite (m_apb_pwrite),
        .m_apb_pprot  (m_apb_pprot),
        .m_apb_paddr  (m_apb_paddr),
        .m_apb_pwdata (m_apb_pwdata),
        .m_apb_pstrb  (m_apb_pstrb),
        .m_apb_pready (m_apb_pready),
        .m_apb_prdata (m_apb_prdata),
        .m_apb_pslverr(m_apb_pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: pready after s_waits low cycles, never when s_never is set.
    logic [31:0] mem [32];
    int          s_wcnt;
    int          s_waits;
    logic        s_err;
    logic        s_never;

    assign m_apb_pready  = m_apb_psel && m_apb_penable && !s_never && (s_wcnt == s_waits);
    assign m_apb_prdata  = mem[m_apb_paddr[6:2]];
    assign m_apb_pslverr = s_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            s_wcnt <= 0;
        end else begin
            if (m_apb_psel && m_apb_penable && !m_apb_pready) s_wcnt <= s_wcnt + 1;
            else s_wcnt <= 0;
            if (m_apb_psel && m_apb_penable && m_apb_pready && m_apb_pwrite && !s_err) begin
                for (int b = 0; b < 4; b++)
                    if (m_apb_pstrb[b]) mem[m_apb_paddr[6:2]][b*8 +: 8] <= m_apb_pwdata[b*8 +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic        err;
        logic        never;
        logic [31:0] exp_rdata;
        logic        exp_slverr;
        logic        exp_to;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    // Waits for rsp_valid from the negedge after the handshake; lat counts cycles from it.
    task automatic wait_rsp(output int lat, output int psel_cnt, output int pen_cnt,
                            output int stab_err, output logic [6:0] c_addr,
                            output logic [3:0] c_strb, output logic [2:0] c_prot,
                            output logic c_write, output logic [31:0] c_wdata);
        lat = 1; psel_cnt = 0; pen_cnt = 0; stab_err = 0;
        c_addr = '0; c_strb = '0; c_prot = '0; c_write = 1'b0; c_wdata = '0;
        while (1) begin
            if (m_apb_psel) psel_cnt++;
            if (m_apb_penable) pen_cnt++;
            if (m_apb_psel && !m_apb_penable) begin
                c_addr = m_apb_paddr; c_strb = m_apb_pstrb; c_prot = m_apb_pprot;
                c_write = m_apb_pwrite; c_wdata = m_apb_pwdata;
            end else if (m_apb_psel) begin
                if (m_apb_paddr !== c_addr || m_apb_pstrb !== c_strb || m_apb_pprot !== c_prot ||
                    m_apb_pwrite !== c_write || m_apb_pwdata !== c_wdata)
                    stab_err++;
            end
            if (rsp_valid || lat >= 40) break;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat, psel_cnt, pen_cnt, stab_err, guard;
        logic [6:0]  c_addr;
        logic [3:0]  c_strb;
        logic [2:0]  c_prot;
        logic        c_write;
        logic [31:0] c_wdata;
        int          exp_psel, exp_pen;
        @(negedge clk);
        req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
        req_strb = v.strb; req_prot = v.prot; req_valid = 1'b1; rsp_ready = 1'b1;
        s_waits = v.waits; s_err = v.err; s_never = v.never;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("v%0d_req_ready", idx), {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat, psel_cnt, pen_cnt, stab_err, c_addr, c_strb, c_prot, c_write, c_wdata);
        exp_psel = v.never ? TB_TIMEOUT + 2 : v.waits + 2;
        exp_pen  = exp_psel - 1;
        check($sformatf("v%0d_rsp_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d_rsp_slverr", idx), {31'b0, rsp_slverr}, {31'b0, v.exp_slverr});
        check($sformatf("v%0d_rsp_timeout", idx), {31'b0, rsp_timeout}, {31'b0, v.exp_to});
        check($sformatf("v%0d_psel_cycles", idx), psel_cnt, exp_psel);
        check($sformatf("v%0d_penable_cycles", idx), pen_cnt, exp_pen);
        check($sformatf("v%0d_apb_stable", idx), stab_err, 0);
        check($sformatf("v%0d_paddr", idx), {25'b0, c_addr}, {25'b0, v.addr});
        check($sformatf("v%0d_pstrb", idx), {28'b0, c_strb}, v.wr ? {28'b0, v.strb} : 32'h0);
        check($sformatf("v%0d_pprot", idx), {29'b0, c_prot}, {29'b0, v.prot});
        check($sformatf("v%0d_pwrite", idx), {31'b0, c_write}, {31'b0, v.wr});
        if (v.wr) check($sformatf("v%0d_pwdata", idx), c_wdata, v.wdata);
        @(posedge clk);
    endtask

    int          lat, psel_cnt, pen_cnt, stab_err, guard;
    logic [6:0]  c_addr;
    logic [3:0]  c_strb;
    logic [2:0]  c_prot;
    logic        c_write;
    logic [31:0] c_wdata;

    initial begin
        //           wr    addr   wdata         strb     prot    wt err never exp_rdata    serr  to  lat
        vecs[0]  = '{1'b1, 7'h08, 32'hDEADBEEF, 4'hF,    3'b000, 0, 0, 0, 32'h00000000, 1'b0, 1'b0, 3};
        vecs[1]  = '{1'b0, 7'h08, 32'h0,        4'hF,    3'b000, 0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 3};
        vecs[2]  = '{1'b1, 7'h0C, 32'h12345678, 4'b0101, 3'b010, 3, 0, 0, 32'h00000000, 1'b0, 1'b0, 6};
        vecs[3]  = '{1'b0, 7'h0C, 32'hFFFFFFFF, 4'hF,    3'b001, 1, 0, 0, 32'h00340078, 1'b0, 1'b0, 4};
        vecs[4]  = '{1'b0, 7'h08, 32'h0,        4'h0,    3'b000, 0, 1, 0, 32'hDEADBEEF, 1'b1, 1'b0, 3};
        vecs[5]  = '{1'b1, 7'h10, 32'hCAFEF00D, 4'hF,    3'b100, 0, 0, 1, 32'h00000000, 1'b1, 1'b1, 7};
        vecs[6]  = '{1'b0, 7'h08, 32'h0,        4'h0,    3'b000, 0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 3};
        vecs[7]  = '{1'b0, 7'h0C, 32'h0,        4'h0,    3'b111, 4, 0, 0, 32'h00340078, 1'b0, 1'b0, 7};
        vecs[8]  = '{1'b1, 7'h00, 32'hAABBCCDD, 4'b1000, 3'b000, 2, 0, 0, 32'h00000000, 1'b0, 1'b0, 5};
        vecs[9]  = '{1'b0, 7'h00, 32'h0,        4'h0,    3'b000, 0, 0, 0, 32'hAA000000, 1'b0, 1'b0, 3};
        vecs[10] = '{1'b1, 7'h14, 32'h55AA55AA, 4'hF,    3'b000, 0, 1, 0, 32'h00000000, 1'b1, 1'b0, 3};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_prot = '0; rsp_ready = 1'b1;
        s_waits = 0; s_err = 1'b0; s_never = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", {31'b0, req_ready}, 32'h0);
        check("reset_psel", {31'b0, m_apb_psel}, 32'h0);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("release_req_ready", {31'b0, req_ready}, 32'h1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Response backpressure with a second request waiting behind it.
        @(negedge clk);
        req_write = 1'b0; req_addr = 7'h08; req_strb = 4'h0; req_prot = 3'b000;
        s_waits = 0; s_err = 1'b0; s_never = 1'b0; rsp_ready = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_addr = 7'h00;
        wait_rsp(lat, psel_cnt, pen_cnt, stab_err, c_addr, c_strb, c_prot, c_write, c_wdata);
        check("bp_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d_rsp_valid", i), {31'b0, rsp_valid}, 32'h1);
            check($sformatf("bp_hold%0d_rdata", i), rsp_rdata, 32'hDEADBEEF);
            check($sformatf("bp_hold%0d_req_ready", i), {31'b0, req_ready}, 32'h0);
            if (i < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_req_ready_after", {31'b0, req_ready}, 32'h1);
        check("bp_rsp_valid_after", {31'b0, rsp_valid}, 32'h0);
        @(negedge clk);
        check("bp_second_setup_psel", {31'b0, m_apb_psel}, 32'h1);
        check("bp_second_setup_penable", {31'b0, m_apb_penable}, 32'h0);
        check("bp_second_paddr", {25'b0, m_apb_paddr}, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_second_rdata", rsp_rdata, 32'hAA000000);
        check("bp_second_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        @(posedge clk);

        // Reset asserted in the middle of ACCESS.
        @(negedge clk);
        req_write = 1'b1; req_addr = 7'h18; req_wdata = 32'h0BADF00D; req_strb = 4'hF;
        s_never = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!m_apb_penable && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rstmid_in_access", {31'b0, m_apb_penable}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("rstmid_psel", {31'b0, m_apb_psel}, 32'h0);
        check("rstmid_penable", {31'b0, m_apb_penable}, 32'h0);
        check("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rstmid_req_ready", {31'b0, req_ready}, 32'h0);
        check("rstmid_pwrite", {31'b0, m_apb_pwrite}, 32'h0);
        @(negedge clk);
        s_never = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_release_req_ready", {31'b0, req_ready}, 32'h1);
        check("rstmid_release_psel", {31'b0, m_apb_psel}, 32'h0);
        run_vec('{1'b0, 7'h18, 32'h0, 4'h0, 3'b000, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3}, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Upstream APB requester for the register-slave test harness: accepts single register transactions on a valid/ready request channel, drives the APB3/APB4 SETUP and ACCESS phases towards the slave's `s_apb_*` port, and returns read data and error status on a valid/ready response channel. One transaction is in flight at a time. A programmable timeout aborts accesses whose slave never asserts PREADY.

## Interface
- `REGWIDTH`, 32: data width in bits; a multiple of 8.
- `G_ADDR_WIDTH`, 7: APB address width; matches the slave's address width for 32 registers of 32 bits.
- `TIMEOUT`, 16: ACCESS-phase wait-cycle limit; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bridge can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  G_ADDR_WIDTH  byte address.
- `req_wdata`  in  REGWIDTH  write data.
- `req_strb`  in  REGWIDTH/8  write byte strobes.
- `req_prot`  in  3  protection attributes.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  REGWIDTH  read data; 0 for writes and for timeouts.
- `rsp_slverr`  out  1  slave error or timeout.
- `rsp_timeout`  out  1  access aborted by the timeout.
- `m_apb_psel`, `m_apb_penable`, `m_apb_pwrite`  out  1 each  APB controls.
- `m_apb_pprot`  out  3  APB protection.
- `m_apb_paddr`  out  G_ADDR_WIDTH  APB address.
- `m_apb_pwdata`  out  REGWIDTH  APB write data.
- `m_apb_pstrb`  out  REGWIDTH/8  APB strobes.
- `m_apb_pready`  in  1  slave ready.
- `m_apb_prdata`  in  REGWIDTH  slave read data.
- `m_apb_pslverr`  in  1  slave error.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, RESP. The reset state is IDLE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, the bridge registers write, addr, wdata, strb and prot, then moves to SETUP.
  - For reads, the registered strb is forced to 0.
- SETUP:
  - `psel` = 1, `penable` = 0, all `m_apb_*` address/data/control outputs are driven from the registers.
  - Moves unconditionally to ACCESS.
- ACCESS:
  - `psel` = 1, `penable` = 1; all other APB outputs are held stable.
  - On `pready` = 1: capture `prdata` (reads only; writes capture 0) and `pslverr` into the response registers, clear `rsp_timeout`, move to RESP.
  - Wait counter: cleared on entry to ACCESS, incremented on each ACCESS cycle with `pready` = 0.
  - Timeout: if `TIMEOUT` > 0 and the counter reaches `TIMEOUT` with `pready` still 0, move to RESP with `rsp_rdata` = 0, `rsp_slverr` = 1, `rsp_timeout` = 1.
  - The counter width is `$clog2(TIMEOUT+1)`, minimum 1 bit; it saturates and never wraps.
- RESP:
  - `psel` = `penable` = 0; `rsp_valid` = 1 and response fields are held.
  - On `rsp_ready`, return to IDLE.
- `req_ready` is 0 in SETUP, ACCESS and RESP, so no request is accepted while one is outstanding.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Reset (asynchronous assertion, any state): all outputs go to 0 immediately. Any in-flight transaction is discarded with no response. Reset release is synchronous to `clk`.

## Timing
- Reset values: `req_ready` = 0 while `rst` = 0, then 1 from the first cycle after release; every other output = 0.
- A request handshaken at edge E produces:
  - SETUP in cycle E+1;
  - ACCESS from E+2;
  - with zero wait states (`pready` = 1 at edge E+3), `rsp_valid` high in cycle E+3.
- Each slave wait state adds one cycle.
- With consumer `rsp_ready` tied high, the minimum request-to-request period is 4 cycles.
- A timeout with `pready` never asserted:
  - `psel` stays high for 1 + `TIMEOUT` + 1 cycles (SETUP, wait cycles, final ACCESS cycle);
  - `rsp_valid` rises in the cycle after that.
- `pready` and the timeout on the same edge: `pready` wins, giving a normal completion with `rsp_timeout` = 0.
- Backpressure: `rsp_valid` stays high with constant data until `rsp_ready`. `req_ready` returns in the cycle after the response handshake.

## Test plan
- Reset mid-ACCESS:
  - Stimulus: assert `rst` = 0 while `psel` = 1.
  - Required: `psel`, `penable` and `rsp_valid` drop to 0 with no clock edge; `req_ready` = 1 one cycle after release.
- Zero-wait write then read:
  - Stimulus: write 0xDEADBEEF to addr 0x08 with strb 0xF, prot 0; then read addr 0x08.
  - Required: write response `rsp_slverr` = 0, `rsp_rdata` = 0; read response `rsp_rdata` = 0xDEADBEEF; each response appears 3 cycles after its request handshake; `pstrb` = 0 during the read.
- Wait states:
  - Stimulus: slave holds `pready` low for 3 ACCESS cycles.
  - Required: `penable` high for 4 cycles; APB outputs stable throughout; `rsp_valid` 6 cycles after the request handshake.
- Slave error:
  - Stimulus: slave returns `pslverr` = 1 with `pready`.
  - Required: `rsp_slverr` = 1, `rsp_timeout` = 0.
- Timeout:
  - Stimulus: `TIMEOUT` = 4, `pready` never asserted.
  - Required: `psel` high 6 cycles; response `rsp_slverr` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0; the next request completes normally.
- Response backpressure:
  - Stimulus: `rsp_ready` held low for 5 cycles while `req_valid` stays high.
  - Required: `rsp_valid` and data held; `req_ready` = 0 throughout; second request accepted the cycle after `rsp_ready`.
